// File: rtl/detector_pkg.sv
// ============================================================================
// detector_pkg : shared constants for the parametrised serial pattern detector
// Revision     : 1.0
// ============================================================================
`default_nettype none

package detector_pkg;

  localparam int   DET_MAX_LEN_DEF = 8;
  localparam int   DET_CNT_W_DEF   = 8;

  localparam logic MODO_SOLAPADO   = 1'b1;
  localparam logic MODO_DISJUNTO   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/detector_secuencia_param_contador.sv
// ============================================================================
// contador_saturado : W-bit up counter that sticks at all-ones; clr beats inc
// Revision          : 1.0
// ============================================================================
`default_nettype none

module contador_saturado #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/detector_secuencia_param.sv
// ============================================================================
// detector_secuencia_param : runtime-loadable serial pattern detector with
//                            overlapping/non-overlapping modes and match count
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module detector_secuencia_param
  import detector_pkg::*;
#(
  parameter int MAX_LEN = DET_MAX_LEN_DEF,
  parameter int CNT_W   = DET_CNT_W_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dato,
  input  logic               valido,
  input  logic               cargar,
  input  logic [MAX_LEN-1:0] patron,
  input  logic [LEN_W-1:0]   longitud,
  input  logic               solapado,
  input  logic               limpiar,
  output logic               detectada,
  output logic [CNT_W-1:0]   cuenta
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] patron_q,   patron_d;
  logic [LEN_W-1:0]   longitud_q, longitud_d;
  logic               solapado_q, solapado_d;
  logic [MAX_LEN-1:0] historia_q, historia_d;
  logic [LEN_W-1:0]   llenado_q,  llenado_d;
  logic               detectada_q, detectada_d;

  logic [MAX_LEN-1:0] mascara;
  logic [MAX_LEN-1:0] historia_sig;
  logic [LEN_W-1:0]   llenado_sig;
  logic               habilitado;
  logic               coincide;

  // Only the low longitud_q bits take part in the comparison.
  always_comb begin
    mascara = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mascara[i] = (LEN_W'(i) < longitud_q);
    end
  end

  assign historia_sig = {historia_q[MAX_LEN-2:0], dato};
  assign llenado_sig  = (llenado_q == LEN_MAX) ? llenado_q : llenado_q + LEN_W'(1);
  assign habilitado   = (longitud_q != '0) && (longitud_q <= LEN_MAX);

  always_comb begin
    patron_d    = patron_q;
    longitud_d  = longitud_q;
    solapado_d  = solapado_q;
    historia_d  = historia_q;
    llenado_d   = llenado_q;
    detectada_d = 1'b0;
    coincide    = 1'b0;

    if (cargar) begin
      patron_d   = patron;
      longitud_d = longitud;
      solapado_d = solapado;
      historia_d = '0;
      llenado_d  = '0;
    end else if (valido) begin
      historia_d = historia_sig;
      llenado_d  = llenado_sig;
      // The fill guard keeps reset-zero history from matching zero patterns.
      if (habilitado && (llenado_sig >= longitud_q) &&
          (((historia_sig ^ patron_q) & mascara) == '0)) begin
        coincide    = 1'b1;
        detectada_d = 1'b1;
        if (solapado_q == MODO_DISJUNTO) begin
          llenado_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      patron_q    <= '0;
      longitud_q  <= '0;
      solapado_q  <= MODO_SOLAPADO;
      historia_q  <= '0;
      llenado_q   <= '0;
      detectada_q <= 1'b0;
    end else begin
      patron_q    <= patron_d;
      longitud_q  <= longitud_d;
      solapado_q  <= solapado_d;
      historia_q  <= historia_d;
      llenado_q   <= llenado_d;
      detectada_q <= detectada_d;
    end
  end

  assign detectada = detectada_q;

  contador_saturado #(
    .W (CNT_W)
  ) u_contador (
    .clk   (clk),
    .reset (reset),
    .inc   (coincide),
    .clr   (limpiar),
    .q     (cuenta)
  );

endmodule

`default_nettype wire

// File: tb/tb_detector_secuencia_param.sv
// Randomised and directed check of detector_secuencia_param against a
// queue-based model of the received bit stream.
`default_nettype none

module tb_detector_secuencia_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       dato;
  logic       valido;
  logic       cargar;
  logic [7:0] patron;
  logic [3:0] longitud;
  logic       solapado;
  logic       limpiar;

  logic       detectada_a, detectada_b;
  logic [7:0] cuenta_a;
  logic [1:0] cuenta_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  detector_secuencia_param u_dut (
    .clk       (clk),
    .reset     (reset),
    .dato      (dato),
    .valido    (valido),
    .cargar    (cargar),
    .patron    (patron),
    .longitud  (longitud),
    .solapado  (solapado),
    .limpiar   (limpiar),
    .detectada (detectada_a),
    .cuenta    (cuenta_a)
  );

  detector_secuencia_param #(.CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .reset     (reset),
    .dato      (dato),
    .valido    (valido),
    .cargar    (cargar),
    .patron    (patron),
    .longitud  (longitud),
    .solapado  (solapado),
    .limpiar   (limpiar),
    .detectada (detectada_b),
    .cuenta    (cuenta_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: the bits received since the last load / non-overlapping match.
  bit         hq[$];
  logic [7:0] m_pat = '0;
  int         m_len = 0;
  bit         m_ovl = 1'b1;
  bit         exp_det = 1'b0;
  int         exp_c8 = 0;
  int         exp_c2 = 0;
  bit         hit;

  always @(posedge clk) begin
    if (reset) begin
      m_pat = '0; m_len = 0; m_ovl = 1'b1;
      hq.delete();
      exp_det = 1'b0; exp_c8 = 0; exp_c2 = 0;
    end else begin
      hit = 1'b0;
      if (cargar) begin
        m_pat = patron; m_len = int'(longitud); m_ovl = solapado;
        hq.delete();
      end else if (valido) begin
        hq.push_back(dato);
        if (hq.size() > 8) void'(hq.pop_front());
        if (m_len >= 1 && m_len <= 8 && hq.size() >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (hq[hq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
        if (hit && !m_ovl) hq.delete();
      end
      exp_det = hit;
      if (limpiar) begin
        exp_c8 = 0; exp_c2 = 0;
      end else if (hit) begin
        if (exp_c8 < 255) exp_c8++;
        if (exp_c2 < 3) exp_c2++;
      end
    end
  end

  always @(negedge clk) begin
    chk("det_a", detectada_a, exp_det);
    chk("det_b", detectada_b, exp_det);
    chk("cnt_a", cuenta_a, exp_c8);
    chk("cnt_b", cuenta_b, exp_c2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valido = 1'b0; cargar = 1'b0; limpiar = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Load, then scramble the config inputs: only cargar may change the setup.
  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic s);
    cargar = 1'b1; patron = p; longitud = l; solapado = s; valido = 1'b0;
    tick();
    cargar = 1'b0;
    patron = 8'($urandom); longitud = 4'($urandom); solapado = 1'($urandom);
  endtask

  // bits[n-1] is fed first; pul gives the literal detectada expected after each.
  task automatic feed(input string nm, input logic [15:0] bits, input int n,
                      input logic [15:0] pul);
    for (int i = 0; i < n; i++) begin
      dato = bits[n-1-i]; valido = 1'b1;
      tick();
      chk(nm, detectada_a, int'(pul[n-1-i]));
    end
    valido = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dato = 1'b0; valido = 1'b0; cargar = 1'b0;
    patron = '0; longitud = '0; solapado = 1'b0; limpiar = 1'b0;
    tick();
    chk("reset_det", detectada_a, 0);
    chk("reset_cnt", cuenta_a, 0);
    reset = 1'b0;

    // Overlapping 1101
    load(8'b0000_1101, 4'd4, 1'b1);
    feed("ovl_pulse", 16'b1101101011101, 13, 16'b0001001000001);
    chk("ovl_count", cuenta_a, 3);

    // Non-overlapping 1101
    limpiar = 1'b1; tick(); limpiar = 1'b0;
    load(8'b0000_1101, 4'd4, 1'b0);
    feed("disj_pulse", 16'b1101101011101, 13, 16'b0001000000001);
    chk("disj_count", cuenta_a, 2);

    // Idle valido=0 cycles in the middle of a match
    load(8'b0000_1101, 4'd4, 1'b1);
    feed("gap_pre", 16'b110, 3, 16'b000);
    for (int i = 0; i < 5; i++) begin
      dato = i[0]; valido = 1'b0;
      tick();
      chk("gap_idle", detectada_a, 0);
    end
    feed("gap_last", 16'b1, 1, 16'b1);
    tick();
    chk("gap_single", detectada_a, 0);

    // Length 1 back-to-back, 2-bit counter saturation, limpiar vs match
    limpiar = 1'b1; tick(); limpiar = 1'b0;
    load(8'h01, 4'd1, 1'b1);
    feed("b2b_pulse", 16'b11111, 5, 16'b11111);
    chk("sat_cnt2", cuenta_b, 3);
    chk("cnt8_five", cuenta_a, 5);
    dato = 1'b1; valido = 1'b1; limpiar = 1'b1;
    tick();
    limpiar = 1'b0; valido = 1'b0;
    chk("clr_pulse", detectada_b, 1);
    chk("clr_cnt2", cuenta_b, 0);

    // 8-bit counter saturation
    dato = 1'b1; valido = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    valido = 1'b0;
    chk("sat_cnt8", cuenta_a, 255);

    // Disabled detection: length 0 after reset, length 9 > MAX_LEN
    do_reset();
    feed("len0", 16'b1111, 4, 16'b0000);
    load(8'hFF, 4'd9, 1'b1);
    feed("len9", 16'hFFFF, 16, 16'h0000);
    load(8'h00, 4'd9, 1'b1);
    feed("len9_zero", 16'h0000, 16, 16'h0000);

    // Zero pattern must not fire on the empty history
    load(8'h00, 4'd3, 1'b1);
    feed("zero_pat", 16'b0000, 4, 16'b0011);

    // Reset mid-stream loses partial match
    do_reset();
    load(8'b0000_1101, 4'd4, 1'b1);
    feed("rst_pre", 16'b110, 3, 16'b000);
    do_reset();
    feed("rst_post", 16'b1, 1, 16'b0);
    load(8'b0000_1101, 4'd4, 1'b1);
    feed("rst_again", 16'b1101, 4, 16'b0001);
    chk("rst_count", cuenta_a, 1);

    // cargar mid-stream discards the concurrent sample and the history
    feed("ld_pre", 16'b110, 3, 16'b000);
    cargar = 1'b1; patron = 8'b0000_1101; longitud = 4'd4; solapado = 1'b1;
    dato = 1'b1; valido = 1'b1;
    tick();
    cargar = 1'b0;
    chk("ld_drop", detectada_a, 0);
    feed("ld_restart", 16'b1101, 4, 16'b0001);

    // Randomised traffic
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 499) == 0);
      cargar   = ($urandom_range(0, 149) == 0);
      limpiar  = ($urandom_range(0, 99) == 0);
      valido   = ($urandom_range(0, 3) != 0);
      dato     = 1'($urandom);
      patron   = 8'($urandom);
      solapado = 1'($urandom);
      longitud = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4))
                                             : 4'($urandom_range(0, 15));
      tick();
    end
    reset = 1'b0; cargar = 1'b0; limpiar = 1'b0; valido = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
